// File: rtl/pipe_pkg.sv
// Shared definitions for the parametrised pipeline stage register:
// state encoding, default counter width and the per-stage bubble masks.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

    localparam int DEFAULT_CNT_W = 16;

    // Control fields sit in the low bits of each legacy bundle; these are cleared on a bubble.
    localparam logic [63:0] IFID_CLR_MASK  = 64'h0000_0000_0000_0001;
    localparam logic [63:0] IDEX_CLR_MASK  = 64'h0000_0000_0000_003F;
    localparam logic [63:0] EXMEM_CLR_MASK = 64'h0000_0000_0000_000F;
    localparam logic [63:0] MEMWB_CLR_MASK = 64'h0000_0000_0000_0003;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer,
// synchronous flush to a masked bubble, occupancy and back-pressure counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int            DW       = 64,
    parameter logic [DW-1:0] CLR_MASK = {DW{1'b1}},
    parameter int            SKID     = 1,
    parameter int            CNT_W    = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    input  logic             flush,
    input  logic             clr_cnt,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_state_t  state_q, state_d;
    logic [DW-1:0] main_q, skid_q;
    logic          in_fire, out_fire;
    logic          load_main, load_skid, main_from_skid, clear_main;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        clear_main     = 1'b0;
        if (flush) begin
            state_d    = ST_EMPTY;
            clear_main = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d   = ST_MAIN;
                        load_main = 1'b1;
                    end
                end
                ST_MAIN: begin
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end else if (in_fire && (SKID != 0)) begin
                        state_d   = ST_FULL;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_d    = ST_EMPTY;
                        clear_main = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d        = ST_MAIN;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Bubble masking is done at the register so out_data never glitches combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (clear_main) begin
                main_q <= main_q & ~CLR_MASK;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end else if (load_main) begin
                main_q <= in_data;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic rdy_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rdy_q <= 1'b1;
                end else begin
                    rdy_q <= (state_d != ST_FULL);
                end
            end
            assign in_ready = rdy_q;
        end else begin : g_comb
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid & ~out_ready),
        .clr (clr_cnt),
        .cnt (stall_cnt)
    );

endmodule
